uart_rx_fifo: RTL

Parametrised, runtime-baud UART receiver with a buffered read interface. It is the successor to the fixed 8N1, single-byte deserializer that feeds the program loader and keyboard path.
- Adds configurable data width, parity and stop bits.
- Adds start-bit glitch rejection and break detection.
- Adds sticky error flags and a show-ahead RX FIFO, so the consumer may stall without losing bytes.
Sits between the board RXD pin and the loader/console logic.

---
 rtl/uart_rx_fifo_pkg.sv | 31 +++
 rtl/uart_rx_fifo_sync_fifo.sv | 62 ++++++
 rtl/uart_rx_fifo.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the buffered UART receiver: parity modes, receive FSM
// encodings, the default bit divisor and the parity check helper.
`ifndef SERIAL_WCNT
`define SERIAL_WCNT 16'd8
`endif

package uart_rx_fifo_pkg;

   localparam int PAR_NONE = 32'sd0;
   localparam int PAR_ODD  = 32'sd1;
   localparam int PAR_EVEN = 32'sd2;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_START   = 3'd1,
      S_DATA    = 3'd2,
      S_PAR     = 3'd3,
      S_STOP    = 3'd4,
      S_BRKWAIT = 3'd5
   } rx_state_t;

   localparam logic [15:0] SERIAL_WCNT_DEF = `SERIAL_WCNT;

   // High when the received parity bit disagrees with the selected mode.
   function automatic logic parity_bad(input logic [8:0] data,
                                       input logic       par_bit,
                                       input logic       odd);
      return (((^data) ^ par_bit) != odd);
   endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO: registered storage, extra-MSB pointers and a
// drop indication for writes that arrive while full without a matching pop.
module sync_fifo #(
   parameter int WIDTH = 32'sd8,
   parameter int DEPTH = 32'sd16
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     drop
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW:0]      wptr_r;
   logic [AW:0]      rptr_r;
   logic             empty_s;
   logic             full_s;
   logic             pop_s;
   logic             push_s;

   assign empty_s = (wptr_r == rptr_r);
   assign full_s  = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
   // A pop on an empty FIFO is ignored, so a simultaneous push still lands.
   assign pop_s   = rd_en && !empty_s;
   assign push_s  = wr_en && (!full_s || pop_s);
   assign drop    = wr_en && full_s && !pop_s;

   assign rd_data = empty_s ? {WIDTH{1'b0}} : mem_r[rptr_r[AW-1:0]];
   assign empty   = empty_s;
   assign count   = wptr_r - rptr_r;

   // Pointer update; both pointers wrap naturally through the extra MSB.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wptr_r <= '0;
         rptr_r <= '0;
      end else begin
         if (push_s) begin
            wptr_r <= wptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rptr_r <= rptr_r + PTR_ONE;
         end
      end
   end

   // Storage write; contents need no reset because the head is masked while empty.
   always_ff @(posedge CLK) begin
      if (push_s) begin
         mem_r[wptr_r[AW-1:0]] <= wr_data;
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// Runtime-baud UART receiver with configurable framing, glitch rejection,
// break detection, sticky error flags and a show-ahead receive FIFO.
module uart_rx_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter int DATA_W      = 32'sd8,
   parameter int PARITY      = 32'sd0,
   parameter int STOP_BITS   = 32'sd1,
   parameter int DIV_W       = 32'sd16,
   parameter int FIFO_DEPTH  = 32'sd16,
   parameter int SYNC_STAGES = 32'sd2
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          RXD,
   input  logic [DIV_W-1:0]              DIV,
   input  logic                          RD_EN,
   output logic [DATA_W-1:0]             RD_DATA,
   output logic                          EMPTY,
   output logic [$clog2(FIFO_DEPTH):0]   COUNT,
   output logic                          FRAME_ERR,
   output logic                          PARITY_ERR,
   output logic                          OVERRUN,
   input  logic                          ERR_CLR,
   output logic                          BREAK_DET
);

   localparam logic [DIV_W-1:0] ONE_DIV   = {{(DIV_W-1){1'b0}}, 1'b1};
   localparam logic [3:0]       LAST_BIT  = 4'(DATA_W - 1);
   localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
   localparam logic             ODD_MODE  = (PARITY == PAR_ODD);

   logic [SYNC_STAGES-1:0] sync_r;
   rx_state_t              state_r;
   logic [DIV_W-1:0]       div_r;
   logic [DIV_W-1:0]       bcnt_r;
   logic [DATA_W-1:0]      shreg_r;
   logic [3:0]             nbit_r;
   logic                   stop_idx_r;
   logic                   stop_bad_r;
   logic                   par_bit_r;
   logic                   par_err_r;
   logic                   push_r;
   logic [DATA_W-1:0]      push_data_r;
   logic                   brk_r;
   logic                   frame_err_r;
   logic                   parity_err_r;
   logic                   overrun_r;

   logic                   rxs_s;
   logic                   bit_end_s;
   logic                   stop_bad_now_s;
   logic                   fifo_drop_s;

   assign rxs_s          = sync_r[SYNC_STAGES-1];
   assign bit_end_s      = (bcnt_r == (div_r - ONE_DIV));
   assign stop_bad_now_s = stop_bad_r | ~rxs_s;

   // RXD synchroniser, idles high so reset never looks like a start bit.
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync_r <= '1;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], RXD};
      end
   end

   // Receive FSM with registered push, break pulse and sticky frame/parity flags.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r      <= S_IDLE;
         div_r        <= '0;
         bcnt_r       <= '0;
         shreg_r      <= '0;
         nbit_r       <= 4'd0;
         stop_idx_r   <= 1'b0;
         stop_bad_r   <= 1'b0;
         par_bit_r    <= 1'b0;
         par_err_r    <= 1'b0;
         push_r       <= 1'b0;
         push_data_r  <= '0;
         brk_r        <= 1'b0;
         frame_err_r  <= 1'b0;
         parity_err_r <= 1'b0;
      end else begin
         push_r <= 1'b0;
         brk_r  <= 1'b0;
         // A new error later in this block overrides the clear.
         if (ERR_CLR) begin
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
         end
         case (state_r)
            S_IDLE: begin
               if (!rxs_s) begin
                  div_r      <= DIV;
                  bcnt_r     <= '0;
                  nbit_r     <= 4'd0;
                  stop_idx_r <= 1'b0;
                  stop_bad_r <= 1'b0;
                  par_bit_r  <= 1'b0;
                  par_err_r  <= 1'b0;
                  state_r    <= S_START;
               end
            end
            S_START: begin
               if (bcnt_r == (div_r >> 1)) begin
                  bcnt_r  <= '0;
                  state_r <= rxs_s ? S_IDLE : S_DATA;
               end else begin
                  bcnt_r <= bcnt_r + ONE_DIV;
               end
            end
            S_DATA: begin
               if (bit_end_s) begin
                  bcnt_r  <= '0;
                  shreg_r <= {rxs_s, shreg_r[DATA_W-1:1]};
                  if (nbit_r == LAST_BIT) begin
                     nbit_r  <= 4'd0;
                     state_r <= (PARITY != PAR_NONE) ? S_PAR : S_STOP;
                  end else begin
                     nbit_r <= nbit_r + 4'd1;
                  end
               end else begin
                  bcnt_r <= bcnt_r + ONE_DIV;
               end
            end
            S_PAR: begin
               if (bit_end_s) begin
                  bcnt_r    <= '0;
                  par_bit_r <= rxs_s;
                  par_err_r <= parity_bad(9'(shreg_r), rxs_s, ODD_MODE);
                  state_r   <= S_STOP;
               end else begin
                  bcnt_r <= bcnt_r + ONE_DIV;
               end
            end
            S_STOP: begin
               if (bit_end_s) begin
                  bcnt_r <= '0;
                  if (stop_idx_r == LAST_STOP) begin
                     // A line held low for the whole frame is a break, not a bad word.
                     if ((shreg_r == '0) && stop_bad_now_s && !par_bit_r) begin
                        brk_r   <= 1'b1;
                        state_r <= S_BRKWAIT;
                     end else if (stop_bad_now_s) begin
                        frame_err_r <= 1'b1;
                        state_r     <= S_IDLE;
                     end else begin
                        push_r      <= 1'b1;
                        push_data_r <= shreg_r;
                        if (par_err_r) begin
                           parity_err_r <= 1'b1;
                        end
                        state_r <= S_IDLE;
                     end
                  end else begin
                     stop_idx_r <= stop_idx_r + 1'b1;
                     stop_bad_r <= stop_bad_now_s;
                  end
               end else begin
                  bcnt_r <= bcnt_r + ONE_DIV;
               end
            end
            S_BRKWAIT: begin
               if (rxs_s) begin
                  state_r <= S_IDLE;
               end
            end
            default: begin
               state_r <= S_IDLE;
            end
         endcase
      end
   end

   // Sticky overrun flag; a drop in the same cycle as ERR_CLR keeps it set.
   always_ff @(posedge CLK) begin
      if (RST) begin
         overrun_r <= 1'b0;
      end else if (fifo_drop_s) begin
         overrun_r <= 1'b1;
      end else if (ERR_CLR) begin
         overrun_r <= 1'b0;
      end
   end

   sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK     (CLK),
      .RST     (RST),
      .wr_en   (push_r),
      .wr_data (push_data_r),
      .rd_en   (RD_EN),
      .rd_data (RD_DATA),
      .empty   (EMPTY),
      .count   (COUNT),
      .drop    (fifo_drop_s)
   );

   assign FRAME_ERR  = frame_err_r;
   assign PARITY_ERR = parity_err_r;
   assign OVERRUN    = overrun_r;
   assign BREAK_DET  = brk_r;

endmodule
